updown_counter_param: RTL and testbench

Parametrised up/down counter: the next generation of the team's fixed 4-bit up/down counter. It adds a configurable width and modulus, a programmable step, synchronous load and clear, a count enable, and a selectable wrap or saturate mode at the boundaries. It also reports boundary events as a one-cycle pulse and as sticky overflow/underflow flags. It is used wherever a timer, address generator or decade counter needs more than free-running 4-bit behaviour.

---
 rtl/updown_counter_param.sv | 98 +++++++++
 tb/tb_updown_counter_param.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable step, load/clear, and
// wrap-or-saturate boundary handling with event pulse and sticky flags.
module updown_counter_param #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0]   MODULUS = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOD_LO  = MODULUS[WIDTH-1:0];

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] up_wrap;
  logic [WIDTH-1:0] dn_sub;
  logic [WIDTH-1:0] dn_wrap;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;

  assign s_eff    = (step > MAX_VAL) ? MAX_VAL : step;
  assign load_eff = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // The up sum keeps the carry bit so the boundary compare sees the true value;
  // the wrapped results are exact modulo 2**WIDTH because they are < MODULUS.
  assign up_sum  = {1'b0, count} + {1'b0, s_eff};
  assign up_wrap = up_sum[WIDTH-1:0] - MOD_LO;
  assign dn_sub  = count - s_eff;
  assign dn_wrap = count + MOD_LO - s_eff;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    ovf_nxt   = ovf;
    udf_nxt   = udf;
    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
      udf_nxt   = 1'b0;
    end else if (load) begin
      count_nxt = load_eff;
    end else if (en && (s_eff != '0)) begin
      if (up_down) begin
        if (up_sum <= MAX_EXT) begin
          count_nxt = up_sum[WIDTH-1:0];
        end else begin
          count_nxt = SATURATE ? MAX_VAL : up_wrap;
          wrap_nxt  = 1'b1;
          ovf_nxt   = 1'b1;
        end
      end else begin
        if (s_eff <= count) begin
          count_nxt = dn_sub;
        end else begin
          count_nxt = SATURATE ? '0 : dn_wrap;
          wrap_nxt  = 1'b1;
          udf_nxt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      ovf   <= ovf_nxt;
      udf   <= udf_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: a wrap-mode and a saturate-mode
// decade counter (WIDTH=4, MAX_VAL=9) driven by shared stimulus.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst, clr, load, en, up_down;
  logic [3:0] load_val, step;

  logic [3:0] w_count, s_count;
  logic       w_at_max, w_at_zero, w_wrap, w_ovf, w_udf;
  logic       s_at_max, s_at_zero, s_wrap, s_ovf, s_udf;

  // Observation vectors: {count, at_max, at_zero, wrap, ovf, udf}
  logic [8:0] w_obs, s_obs;
  assign w_obs = {w_count, w_at_max, w_at_zero, w_wrap, w_ovf, w_udf};
  assign s_obs = {s_count, s_at_max, s_at_zero, s_wrap, s_ovf, s_udf};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_down(up_down), .step(step),
    .count(w_count), .at_max(w_at_max), .at_zero(w_at_zero),
    .wrap(w_wrap), .ovf(w_ovf), .udf(w_udf)
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_down(up_down), .step(step),
    .count(s_count), .at_max(s_at_max), .at_zero(s_at_zero),
    .wrap(s_wrap), .ovf(s_ovf), .udf(s_udf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0;
    up_down = 1'b1; step = 4'd0; load_val = 4'd0;
    #1;
    tests++;
    if (w_obs !== 9'b0000_01_000) begin
      fails++; $display("FAIL reset_async_w got=%b exp=%b", w_obs, 9'b0000_01_000);
    end
    repeat (2) tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++;
      if (w_obs !== 9'b0000_01_000) begin
        fails++; $display("FAIL hold_w cyc=%0d got=%b exp=%b", i, w_obs, 9'b0000_01_000);
      end
      tests++;
      if (s_obs !== 9'b0000_01_000) begin
        fails++; $display("FAIL hold_s cyc=%0d got=%b exp=%b", i, s_obs, 9'b0000_01_000);
      end
    end
  endtask

  task automatic test_decade_up;
    logic [3:0] ew, es;
    logic [8:0] xw, xs;
    step = 4'd1; up_down = 1'b1; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick;
      ew = 4'(i % 10);
      es = (i > 9) ? 4'd9 : 4'(i);
      xw = {ew, ew == 4'd9, ew == 4'd0, i == 10, i >= 10, 1'b0};
      xs = {es, es == 4'd9, es == 4'd0, i >= 10, i >= 10, 1'b0};
      tests++;
      if (w_obs !== xw) begin
        fails++; $display("FAIL decade_w cyc=%0d got=%b exp=%b", i, w_obs, xw);
      end
      tests++;
      if (s_obs !== xs) begin
        fails++; $display("FAIL decade_s cyc=%0d got=%b exp=%b", i, s_obs, xs);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_step_wrap_down;
    load = 1'b1; load_val = 4'd2;
    tick;
    tests++;
    if (w_obs !== {4'd2, 5'b00_010}) begin
      fails++; $display("FAIL load2_w got=%b exp=%b", w_obs, {4'd2, 5'b00_010});
    end
    load = 1'b0; en = 1'b1; step = 4'd5; up_down = 1'b0;
    tick;
    tests++;
    if (w_obs !== {4'd7, 5'b00_111}) begin
      fails++; $display("FAIL stepdown_w got=%b exp=%b", w_obs, {4'd7, 5'b00_111});
    end
    tests++;
    if (s_obs !== {4'd0, 5'b01_111}) begin
      fails++; $display("FAIL stepdown_s got=%b exp=%b", s_obs, {4'd0, 5'b01_111});
    end
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    tick;
    tests++;
    if (w_obs !== {4'd9, 5'b10_011}) begin
      fails++; $display("FAIL loadclamp_w got=%b exp=%b", w_obs, {4'd9, 5'b10_011});
    end
    tests++;
    if (s_obs !== {4'd9, 5'b10_011}) begin
      fails++; $display("FAIL loadclamp_s got=%b exp=%b", s_obs, {4'd9, 5'b10_011});
    end
    load = 1'b0;
  endtask

  task automatic test_saturate;
    clr = 1'b1;
    tick;
    tests++;
    if (s_obs !== {4'd0, 5'b01_000}) begin
      fails++; $display("FAIL clr_s got=%b exp=%b", s_obs, {4'd0, 5'b01_000});
    end
    clr = 1'b0; load = 1'b1; load_val = 4'd8;
    tick;
    load = 1'b0; en = 1'b1; up_down = 1'b1; step = 4'd3;
    tick;
    tests++;
    if (s_obs !== {4'd9, 5'b10_110}) begin
      fails++; $display("FAIL sat_up_s got=%b exp=%b", s_obs, {4'd9, 5'b10_110});
    end
    tests++;
    if (w_obs !== {4'd1, 5'b00_110}) begin
      fails++; $display("FAIL sat_up_w got=%b exp=%b", w_obs, {4'd1, 5'b00_110});
    end
    tick;
    tests++;
    if (s_obs !== {4'd9, 5'b10_110}) begin
      fails++; $display("FAIL sat_clamped_up_s got=%b exp=%b", s_obs, {4'd9, 5'b10_110});
    end
    tests++;
    if (w_obs !== {4'd4, 5'b00_010}) begin
      fails++; $display("FAIL sat_up2_w got=%b exp=%b", w_obs, {4'd4, 5'b00_010});
    end
    up_down = 1'b0; step = 4'd15;
    tick;
    tests++;
    if (s_obs !== {4'd0, 5'b01_010}) begin
      fails++; $display("FAIL sat_bigdown_s got=%b exp=%b", s_obs, {4'd0, 5'b01_010});
    end
    tests++;
    if (w_obs !== {4'd5, 5'b00_111}) begin
      fails++; $display("FAIL bigdown_w got=%b exp=%b", w_obs, {4'd5, 5'b00_111});
    end
    tick;
    tests++;
    if (s_obs !== {4'd0, 5'b01_111}) begin
      fails++; $display("FAIL sat_clamped_down_s got=%b exp=%b", s_obs, {4'd0, 5'b01_111});
    end
    tests++;
    if (w_obs !== {4'd6, 5'b00_111}) begin
      fails++; $display("FAIL bigdown2_w got=%b exp=%b", w_obs, {4'd6, 5'b00_111});
    end
    step = 4'd0;
    tick;
    tests++;
    if (s_obs !== {4'd0, 5'b01_011}) begin
      fails++; $display("FAIL zerostep_s got=%b exp=%b", s_obs, {4'd0, 5'b01_011});
    end
    tests++;
    if (w_obs !== {4'd6, 5'b00_011}) begin
      fails++; $display("FAIL zerostep_w got=%b exp=%b", w_obs, {4'd6, 5'b00_011});
    end
    en = 1'b0;
  endtask

  task automatic test_priority;
    clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd4; step = 4'd1; up_down = 1'b1;
    tick;
    tests++;
    if (w_obs !== {4'd0, 5'b01_000}) begin
      fails++; $display("FAIL prio_clr_w got=%b exp=%b", w_obs, {4'd0, 5'b01_000});
    end
    tests++;
    if (s_obs !== {4'd0, 5'b01_000}) begin
      fails++; $display("FAIL prio_clr_s got=%b exp=%b", s_obs, {4'd0, 5'b01_000});
    end
    clr = 1'b0;
    tick;
    tests++;
    if (w_obs !== {4'd4, 5'b00_000}) begin
      fails++; $display("FAIL prio_load_w got=%b exp=%b", w_obs, {4'd4, 5'b00_000});
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [3:0] e;
    load = 1'b1; load_val = 4'd9;
    tick;
    load = 1'b0; en = 1'b1; up_down = 1'b1; step = 4'd9;
    for (int i = 1; i <= 3; i++) begin
      tick;
      e = 4'(9 - i);
      tests++;
      if (w_obs !== {e, 5'b00_110}) begin
        fails++; $display("FAIL b2b_w cyc=%0d got=%b exp=%b", i, w_obs, {e, 5'b00_110});
      end
      tests++;
      if (s_obs !== {4'd9, 5'b10_110}) begin
        fails++; $display("FAIL b2b_s cyc=%0d got=%b exp=%b", i, s_obs, {4'd9, 5'b10_110});
      end
    end
    up_down = 1'b0;
    tick;
    tests++;
    if (w_obs !== {4'd7, 5'b00_111}) begin
      fails++; $display("FAIL b2b_dir_w got=%b exp=%b", w_obs, {4'd7, 5'b00_111});
    end
    tests++;
    if (s_obs !== {4'd0, 5'b01_010}) begin
      fails++; $display("FAIL b2b_dir_s got=%b exp=%b", s_obs, {4'd0, 5'b01_010});
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset;
    clr = 1'b1;
    tick;
    clr = 1'b0; load = 1'b1; load_val = 4'd5;
    tick;
    load = 1'b0; en = 1'b1; up_down = 1'b1; step = 4'd1;
    tick;
    tests++;
    if (w_obs !== {4'd6, 5'b00_000}) begin
      fails++; $display("FAIL pre_rst_w got=%b exp=%b", w_obs, {4'd6, 5'b00_000});
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (w_obs !== {4'd0, 5'b01_000}) begin
      fails++; $display("FAIL async_rst_w got=%b exp=%b", w_obs, {4'd0, 5'b01_000});
    end
    tests++;
    if (s_obs !== {4'd0, 5'b01_000}) begin
      fails++; $display("FAIL async_rst_s got=%b exp=%b", s_obs, {4'd0, 5'b01_000});
    end
    tick;
    tests++;
    if (w_obs !== {4'd0, 5'b01_000}) begin
      fails++; $display("FAIL rst_held_w got=%b exp=%b", w_obs, {4'd0, 5'b01_000});
    end
    rst = 1'b0;
    tick;
    tests++;
    if (w_obs !== {4'd1, 5'b00_000}) begin
      fails++; $display("FAIL post_rst_w got=%b exp=%b", w_obs, {4'd1, 5'b00_000});
    end
    tick;
    tests++;
    if (s_obs !== {4'd2, 5'b00_000}) begin
      fails++; $display("FAIL post_rst2_s got=%b exp=%b", s_obs, {4'd2, 5'b00_000});
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_decade_up;
    test_step_wrap_down;
    test_saturate;
    test_priority;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "simulation time limit reached");
  end

endmodule
